i2c_byte_mon: RTL
=================

# i2c_byte_mon

Byte-level I2C receiver/monitor sitting directly downstream of `i2c_bby_detect` and the SCL instance of `i2c_edge_detect`. Consumes the filtered SDA level, SCL edge pulses and START/STOP pulses, then assembles MSB-first bytes with their ACK bit. Completed bytes go out through a single-entry valid/ready register with sticky overrun. Feeds the slave/register-file logic.

## Interface
- `ADDR`, 7'h50: 7-bit target address; used only when the address filter is compiled in.
- `clk` in 1: system clock; all logic on posedge.
- `rst` in 1: asynchronous, active-high reset.
- `sda` in 1: filtered SDA level (the edge detector's settled `lin_l`-equivalent).
- `scl_lohi` in 1: one-cycle pulse, SCL rising edge.
- `sta` in 1: one-cycle START / repeated-START pulse.
- `sto` in 1: one-cycle STOP pulse.
- `dat` out 8: received byte, MSB = first bit on the bus.
- `dat_ack` out 1: 9th bit sampled (0 = ACK, 1 = NACK).
- `dat_first` out 1: byte is the first after START (address + R/W).
- `dat_vld` out 1: output register holds an unread byte.
- `dat_rdy` in 1: consumer accepts when `dat_vld && dat_rdy`.
- `ovr` out 1: sticky; a completed byte was dropped.
- `ovr_clr` in 1: clears `ovr`.

## Operation
- Reset values: `dat`=0, `dat_ack`=1, `dat_first`=0, `dat_vld`=0, `ovr`=0. State is IDLE, bit count 0, first flag 0.
- States:
  - IDLE: waits for `sta`.
  - BITS: count 0..7; each `scl_lohi` shifts `sda` in at the LSB and increments the count; the 8th edge moves to ACK.
  - ACK: the next `scl_lohi` samples `sda` as the ack bit, completes the byte, and returns to BITS with count 0.
- `sta` in any state, including mid-byte or ACK: enter BITS, count 0, first flag 1. The partial byte is discarded.
- `sto` in any state: enter IDLE and discard the partial byte. A completed byte already in the output register is kept.
- Priority when pulses coincide: `sta` > `sto` > `scl_lohi`. A coincident `scl_lohi` is ignored.
- `scl_lohi` in IDLE is ignored.
- On completion:
  - If the output is free (`!dat_vld`, or `dat_vld && dat_rdy` in the same cycle), load `dat`, `dat_ack`, `dat_first`, set `dat_vld`, then clear the first flag.
  - Otherwise drop the byte and set `ovr`; the output register is unchanged. The first flag is still cleared.
- `dat_vld` clears on handshake when no new byte is loaded in the same cycle.
- `ovr`:
  - Set wins over a simultaneous `ovr_clr`.
  - Unaffected by `sta`/`sto`; only `rst` and `ovr_clr` clear it.
- Output data stays stable while `dat_vld && !dat_rdy`.

## Timing
- Completion latency: `dat_vld` rises on the clock edge that registers the 9th `scl_lohi` of the byte (1 cycle after the pulse is presented).
- Throughput: one byte per 9 SCL periods; the consumer has ≥ 9 SCL rising edges before overrun.
- `sta`/`sto` take effect on the same clock edge they are sampled; no pipeline.
- `dat_rdy` may be held high permanently; there is no combinational path from `dat_rdy` to `dat_vld`.

## Configuration
- Macro: `I2C_MON_ADDR_FILTER_EN`.
- Defined:
  - The first byte of a transfer is compared on `dat[7:1] == ADDR`.
  - On mismatch, that byte and all following bytes up to the next `sta` are suppressed: no `dat_vld`, no `ovr`.
  - On match, everything is presented as normal.
- Undefined: no comparison, all bytes presented, `ADDR` unused.

## Structure
- Shared package holds:
  - the state encoding (IDLE/BITS/ACK);
  - bit-count width (4 bits);
  - the constant `I2C_BITS_PER_BYTE` = 8;
  - the ACK/NACK level constants.
- One sub-module, `i2c_shift_in`:
  - 8-bit shift register plus bit counter;
  - inputs: `clk`, `rst`, `clr`, `shift`, `din`;
  - outputs: `q`, `full`.
- The top level holds the FSM, the output register/handshake, `ovr` and the optional filter.

## Test plan
- START, bits 1010_0000, ACK=0, `dat_rdy`=1 → one `dat_vld` pulse with `dat`=8'hA0, `dat_ack`=0, `dat_first`=1.
- START, 8'hA0/ACK, 8'h3C/NACK, STOP, with `dat_rdy`=1 → two bytes; the second has `dat`=8'h3C, `dat_ack`=1, `dat_first`=0. State returns to IDLE.
- `dat_rdy`=0, two complete bytes 8'h11, 8'h22:
  - `dat` stays 8'h11 and `ovr`=1;
  - after `ovr_clr` and a handshake, `ovr`=0 and `dat_vld`=0.
- Repeated START after 4 bits, then 8'h5A/ACK → partial discarded; the output is 8'h5A with `dat_first`=1.
- Reset or STOP mid-byte:
  - asserting `rst` mid-byte returns all outputs to their reset values immediately (async);
  - STOP after 5 bits → no `dat_vld`.
- With `I2C_MON_ADDR_FILTER_EN` and `ADDR`=7'h50:
  - address byte 8'hA1 followed by data → both bytes presented;
  - address byte 8'hA2 followed by data → nothing presented, `ovr`=0.

Source files
------------

// File: rtl/i2c_byte_mon_pkg.sv
// Shared types and constants for the I2C byte monitor: FSM encoding, bit-count
// width, bits per byte, ACK/NACK levels and the address-compare helper.
package i2c_byte_mon_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BITS = 2'd1,
        ST_ACK  = 2'd2
    } state_e;

    localparam int unsigned I2C_CNT_W         = 4;
    localparam int unsigned I2C_BITS_PER_BYTE = 8;
    localparam logic        I2C_ACK           = 1'b0;
    localparam logic        I2C_NACK          = 1'b1;

    typedef logic [I2C_CNT_W-1:0]         bit_cnt_t;
    typedef logic [I2C_BITS_PER_BYTE-1:0] byte_t;

    // The address phase carries the 7-bit address in the upper bits, R/W in bit 0.
    function automatic logic addr_match(input byte_t b, input logic [6:0] addr);
        return (b[7:1] == addr);
    endfunction

endpackage

// File: rtl/i2c_byte_mon_if.sv
// Bus-side signal bundle of the I2C byte monitor. The slave modport is the
// monitor itself; the master modport is the upstream detector plus consumer.
interface i2c_byte_mon_if;
    logic       sda;
    logic       scl_lohi;
    logic       sta;
    logic       sto;
    logic [7:0] dat;
    logic       dat_ack;
    logic       dat_first;
    logic       dat_vld;
    logic       dat_rdy;
    logic       ovr;
    logic       ovr_clr;

    modport slave (
        input  sda, scl_lohi, sta, sto, dat_rdy, ovr_clr,
        output dat, dat_ack, dat_first, dat_vld, ovr
    );

    modport master (
        output sda, scl_lohi, sta, sto, dat_rdy, ovr_clr,
        input  dat, dat_ack, dat_first, dat_vld, ovr
    );
endinterface

// File: rtl/i2c_shift_in.sv
// MSB-first serial-to-parallel shifter with a bit counter; full flags a
// complete byte and stops further shifting until cleared.
module i2c_shift_in
    import i2c_byte_mon_pkg::*;
(
    input  logic  clk,
    input  logic  rst,
    input  logic  clr,
    input  logic  shift,
    input  logic  din,
    output byte_t q,
    output logic  full
);

    byte_t    q_q;
    byte_t    q_d;
    bit_cnt_t cnt_q;
    bit_cnt_t cnt_d;

    assign q    = q_q;
    assign full = (cnt_q == bit_cnt_t'(I2C_BITS_PER_BYTE));

    // Next shift-register contents and bit count.
    always_comb begin
        q_d   = q_q;
        cnt_d = cnt_q;
        if (clr) begin
            q_d   = '0;
            cnt_d = '0;
        end else if (shift && !full) begin
            q_d   = {q_q[I2C_BITS_PER_BYTE-2:0], din};
            cnt_d = cnt_q + 4'd1;
        end else begin
            q_d   = q_q;
            cnt_d = cnt_q;
        end
    end

    // Shift register and counter flops.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            q_q   <= '0;
            cnt_q <= '0;
        end else begin
            q_q   <= q_d;
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/i2c_byte_mon.sv
// I2C byte receiver/monitor: START/STOP-framed byte assembly with ACK bit,
// single-entry valid/ready output and sticky overrun. Optional address filter
// is compiled in with I2C_MON_ADDR_FILTER_EN.
module i2c_byte_mon
    import i2c_byte_mon_pkg::*;
#(
    parameter logic [6:0] ADDR = 7'h50
) (
    input  logic           clk,
    input  logic           rst,
    i2c_byte_mon_if.slave  bus
);

    state_e state_q;
    state_e state_d;
    logic   first_q;
    logic   first_d;
    byte_t  dat_q;
    byte_t  dat_d;
    logic   ack_q;
    logic   ack_d;
    logic   dfirst_q;
    logic   dfirst_d;
    logic   vld_q;
    logic   vld_d;
    logic   ovr_q;
    logic   ovr_d;

    byte_t  shift_q_s;
    logic   full_s;
    logic   scl_s;
    logic   ack_phase_s;
    logic   shift_s;
    logic   done_s;
    logic   clr_s;
    logic   present_s;
    logic   free_s;
    logic   load_s;
    logic   drop_s;

    // START beats STOP beats an SCL edge, so an edge is live only when alone.
    assign scl_s       = bus.scl_lohi & ~bus.sta & ~bus.sto;
    assign ack_phase_s = (state_q == ST_ACK) | ((state_q == ST_BITS) & full_s);
    assign shift_s     = scl_s & (state_q == ST_BITS) & ~full_s;
    assign done_s      = scl_s & ack_phase_s;
    assign clr_s       = bus.sta | bus.sto | done_s;

    i2c_shift_in u_shift (
        .clk   (clk),
        .rst   (rst),
        .clr   (clr_s),
        .shift (shift_s),
        .din   (bus.sda),
        .q     (shift_q_s),
        .full  (full_s)
    );

`ifdef I2C_MON_ADDR_FILTER_EN
    logic filt_q;
    logic filt_d;
    logic miss_s;

    assign miss_s    = first_q & ~addr_match(shift_q_s, ADDR);
    assign present_s = ~filt_q & ~miss_s;

    // Suppression latch: set by a mismatching address byte, cleared by START.
    always_comb begin
        filt_d = filt_q;
        if (bus.sta) begin
            filt_d = 1'b0;
        end else if (done_s && miss_s) begin
            filt_d = 1'b1;
        end else begin
            filt_d = filt_q;
        end
    end

    // Suppression flop.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            filt_q <= 1'b0;
        end else begin
            filt_q <= filt_d;
        end
    end
`else
    logic unused_addr_s;

    assign unused_addr_s = ^ADDR;
    assign present_s     = 1'b1;
`endif

    assign free_s = ~vld_q | bus.dat_rdy;
    assign load_s = done_s & present_s & free_s;
    assign drop_s = done_s & present_s & ~free_s;

    // FSM next state; a full shifter in BITS already counts as the ACK phase.
    always_comb begin
        state_d = state_q;
        if (bus.sta) begin
            state_d = ST_BITS;
        end else if (bus.sto) begin
            state_d = ST_IDLE;
        end else begin
            case (state_q)
                ST_IDLE: state_d = ST_IDLE;
                ST_BITS: begin
                    if (done_s) begin
                        state_d = ST_BITS;
                    end else if (full_s) begin
                        state_d = ST_ACK;
                    end else begin
                        state_d = ST_BITS;
                    end
                end
                ST_ACK: begin
                    if (done_s) begin
                        state_d = ST_BITS;
                    end else begin
                        state_d = ST_ACK;
                    end
                end
                default: state_d = ST_IDLE;
            endcase
        end
    end

    // Output register, handshake, overrun and first-byte flag.
    always_comb begin
        dat_d    = dat_q;
        ack_d    = ack_q;
        dfirst_d = dfirst_q;
        vld_d    = vld_q;
        ovr_d    = ovr_q;
        first_d  = first_q;
        if (load_s) begin
            dat_d    = shift_q_s;
            ack_d    = bus.sda;
            dfirst_d = first_q;
            vld_d    = 1'b1;
        end else if (vld_q && bus.dat_rdy) begin
            vld_d    = 1'b0;
        end else begin
            vld_d    = vld_q;
        end
        if (drop_s) begin
            ovr_d = 1'b1;
        end else if (bus.ovr_clr) begin
            ovr_d = 1'b0;
        end else begin
            ovr_d = ovr_q;
        end
        if (bus.sta) begin
            first_d = 1'b1;
        end else if (done_s) begin
            first_d = 1'b0;
        end else begin
            first_d = first_q;
        end
    end

    // State and output flops.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= ST_IDLE;
            first_q  <= 1'b0;
            dat_q    <= 8'h00;
            ack_q    <= I2C_NACK;
            dfirst_q <= 1'b0;
            vld_q    <= 1'b0;
            ovr_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            first_q  <= first_d;
            dat_q    <= dat_d;
            ack_q    <= ack_d;
            dfirst_q <= dfirst_d;
            vld_q    <= vld_d;
            ovr_q    <= ovr_d;
        end
    end

    assign bus.dat       = dat_q;
    assign bus.dat_ack   = ack_q;
    assign bus.dat_first = dfirst_q;
    assign bus.dat_vld   = vld_q;
    assign bus.ovr       = ovr_q;

endmodule
